// File: rtl/ws2812_chain_driver_if.sv
// Pixel-write and frame-control bundle between the animation logic (master)
// and the WS2812 chain driver (slave). The serial LED pin is not part of it.
interface ws2812_chain_driver_if #(
  parameter int NUM_LEDS = 12
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_err;
  logic [7:0]    brightness;
  logic          start;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, brightness, start,
    input  wr_err, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, brightness, start,
    output wr_err, busy, done
  );
endinterface

// File: rtl/ws2812_chain_driver.sv
// WS2812B chain driver: per-LED GRB pixel buffer, global brightness scaling,
// one frame streamed on led_dout per start request, followed by latch time.
module ws2812_chain_driver #(
  parameter int NUM_LEDS = 12,
  parameter int T0H_CYC  = 16,
  parameter int T1H_CYC  = 32,
  parameter int TBIT_CYC = 50,
  parameter int TRES_CYC = 2400
) (
  input  logic                  clk,
  input  logic                  res_n,
  ws2812_chain_driver_if.slave  bus,
  output logic                  led_dout
);

  localparam int AW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int MAXC = (TBIT_CYC > TRES_CYC) ? TBIT_CYC : TRES_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [AW:0]   LED_LIMIT = (AW+1)'(NUM_LEDS);
  localparam logic [AW-1:0] LAST_LED  = AW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] T0H_LAST  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1H_LAST  = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] TRES_LAST = CW'(TRES_CYC - 1);

  // Timing parameters that cannot produce a valid waveform stop elaboration.
  generate
    if (!((T0H_CYC >= 1) && (T0H_CYC < T1H_CYC) && (T1H_CYC < TBIT_CYC) &&
          (TRES_CYC >= 1) && (NUM_LEDS >= 1))) begin : g_bad_params
      $error("ws2812_chain_driver: illegal timing or LED count parameters");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  state_t        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;       // cycle position inside bit / latch
  logic [AW-1:0] led_idx_q,  led_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;  // 0=G, 1=R, 2=B
  logic [2:0]    bit_idx_q,  bit_idx_d;   // bits already sent of current byte
  logic [7:0]    shift_q,    shift_d;     // scaled byte, MSB is the live bit
  logic [7:0]    bright_q,   bright_d;
  logic          led_q,      led_d;
  logic          done_q,     done_d;
  logic          wr_err_q,   wr_err_d;
  logic [23:0]   pixel_q [NUM_LEDS];
  logic [23:0]   pixel_d [NUM_LEDS];

  logic busy;
  logic wr_accept;

  assign busy      = (state_q != S_IDLE);
  assign wr_accept = bus.wr_en && !busy && ({1'b0, bus.wr_addr} < LED_LIMIT);

  // Brightness scale: (c * (b + 1)) >> 8, so 255 is identity and 0 blanks.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    return 8'(({9'd0, c} * ({9'd0, b} + 17'd1)) >> 8);
  endfunction

  // Colour byte select in transmit order G, R, B.
  function automatic logic [7:0] byte_sel(input logic [23:0] p, input logic [1:0] sel);
    case (sel)
      2'd0:    return p[23:16];
      2'd1:    return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

  // Per-entry write mux; a write is only taken while idle and in range.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
      assign pixel_d[gi] = (wr_accept && (bus.wr_addr == AW'(gi))) ? bus.wr_data
                                                                   : pixel_q[gi];
    end
  endgenerate

  // Frame sequencer: next state, counters and byte fetch/scale.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    led_idx_d  = led_idx_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    bright_d   = bright_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bright_d   = bus.brightness;
          led_idx_d  = '0;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          cnt_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d = scale(byte_sel(pixel_q[0], 2'd0), bright_q);
        cnt_d   = '0;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == (shift_q[7] ? T1H_LAST : T0H_LAST)) begin
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == TBIT_LAST) begin
          // Last LOW cycle: advance to the next bit with no idle gap.
          cnt_d   = '0;
          state_d = S_HIGH;
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end else begin
            bit_idx_d = '0;
            if (byte_idx_q != 2'd2) begin
              byte_idx_d = byte_idx_q + 2'd1;
              shift_d    = scale(byte_sel(pixel_q[led_idx_q], byte_idx_q + 2'd1), bright_q);
            end else if (led_idx_q != LAST_LED) begin
              led_idx_d  = led_idx_q + AW'(1);
              byte_idx_d = '0;
              shift_d    = scale(byte_sel(pixel_q[led_idx_q + AW'(1)], 2'd0), bright_q);
            end else begin
              state_d = S_LATCH;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == TRES_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered pin and status pulses, aligned with the state they describe.
  always_comb begin
    led_d    = (state_d == S_HIGH);
    wr_err_d = bus.wr_en && !wr_accept;
  end

  // State, counters and pixel buffer; reset clears everything at once.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      led_idx_q  <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      bright_q   <= '0;
      led_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        pixel_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      led_idx_q  <= led_idx_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      bright_q   <= bright_d;
      led_q      <= led_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
      pixel_q    <= pixel_d;
    end
  end

  assign led_dout   = led_q;
  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.wr_err = wr_err_q;

endmodule
